// File: rtl/adder_tb_pkg.sv
// Shared types and sizing helpers for the exhaustive adder stimulus generator.
// Index layout is {cin, b, a}; TOTAL is the number of distinct vectors.
package adder_tb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } gen_state_t;

  localparam int unsigned DEFAULT_WIDTH = 32'd4;

  function automatic int unsigned idx_width(input int unsigned width);
    return 32'd2 * width + 32'd1;
  endfunction

  function automatic int unsigned total_vectors(input int unsigned width);
    return 32'd1 << idx_width(width);
  endfunction

endpackage

// File: rtl/adder_gap_timer.sv
// Loadable down-counter that paces idle cycles between accepted vectors.
// With GAP=0 no counter exists and expired is permanently asserted.
module adder_gap_timer #(
  parameter int unsigned GAP = 32'd0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expired
);

  if (GAP == 32'd0) begin : g_none
    logic [2:0] unused_s;
    assign unused_s = {load, rst_n, clk};
    assign expired  = 1'b1;
  end else begin : g_timer
    localparam int unsigned CW = $clog2(GAP + 32'd1);
    logic [CW-1:0] cnt_r;

    // load takes GAP-1 so that exactly GAP idle cycles elapse before expiry
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_r <= {CW{1'b0}};
      end else if (load) begin
        cnt_r <= CW'(GAP - 32'd1);
      end else if (cnt_r != {CW{1'b0}}) begin
        cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
    end

    assign expired = (cnt_r == {CW{1'b0}});
  end

endmodule

// File: rtl/adder_vector_gen.sv
// Exhaustive {cin, b, a} stimulus generator for the adder, offered one vector
// at a time over valid/ready with an optional idle gap after each accept.
module adder_vector_gen
  import adder_tb_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned GAP   = 32'd0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 vec_ready,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  output logic                 cin,
  output logic                 vec_valid,
  output logic                 vec_last,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH+1:0]   vec_count
);

  localparam int unsigned IW = idx_width(WIDTH);
  localparam int unsigned CW = IW + 32'd1;
  localparam logic [CW-1:0] TOTAL    = CW'(total_vectors(WIDTH));
  localparam logic [IW-1:0] LAST_IDX = IW'(TOTAL - {{(CW-1){1'b0}}, 1'b1});

  gen_state_t    state_r, state_s;
  logic [IW-1:0] idx_r, idx_s;
  logic [CW-1:0] count_r, count_s;
  logic          valid_r, valid_s;
  logic          last_r, last_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic          load_s;
  logic          expired_s;

  adder_gap_timer #(.GAP(GAP)) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load_s),
    .expired (expired_s)
  );

  // Next-state, index and counter; flag outputs are derived from the next state
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    count_s = count_r;
    load_s  = 1'b0;
    if (abort) begin
      state_s = ST_IDLE;
      idx_s   = {IW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_s = ST_OFFER;
            idx_s   = {IW{1'b0}};
            count_s = {CW{1'b0}};
          end else begin
            state_s = state_r;
          end
        end
        ST_OFFER: begin
          if (vec_ready) begin
            count_s = count_r + {{(CW-1){1'b0}}, 1'b1};
            if (idx_r == LAST_IDX) begin
              state_s = ST_DONE;
            end else begin
              idx_s = idx_r + {{(IW-1){1'b0}}, 1'b1};
              if (GAP == 32'd0) begin
                state_s = ST_OFFER;
              end else begin
                state_s = ST_GAP;
                load_s  = 1'b1;
              end
            end
          end else begin
            state_s = ST_OFFER;
          end
        end
        ST_GAP: begin
          if (expired_s) begin
            state_s = ST_OFFER;
          end else begin
            state_s = ST_GAP;
          end
        end
        default: begin
          state_s = ST_IDLE;
          idx_s   = {IW{1'b0}};
        end
      endcase
    end
    valid_s = (state_s == ST_OFFER);
    busy_s  = (state_s == ST_OFFER) || (state_s == ST_GAP);
    done_s  = (state_s == ST_DONE);
    last_s  = valid_s && (idx_s == LAST_IDX);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      idx_r   <= {IW{1'b0}};
      count_r <= {CW{1'b0}};
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      count_r <= count_s;
      valid_r <= valid_s;
      last_r  <= last_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign a         = idx_r[WIDTH-1:0];
  assign b         = idx_r[2*WIDTH-1:WIDTH];
  assign cin       = idx_r[IW-1];
  assign vec_valid = valid_r;
  assign vec_last  = last_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign vec_count = count_r;

endmodule

// File: tb/tb_adder_vector_gen.sv
// Directed bench for adder_vector_gen: one back-to-back instance (GAP=0) and
// one paced instance (GAP=3), checked against hand-derived sweep expectations.
module tb_adder_vector_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start0, abort0, ready0;
  logic [3:0] a0, b0;
  logic       cin0, valid0, last0, busy0, done0;
  logic [9:0] count0;
  logic       start3, abort3, ready3;
  logic [3:0] a3, b3;
  logic       cin3, valid3, last3, busy3, done3;
  logic [9:0] count3;

  int n_cmp = 0;
  int n_err = 0;

  adder_vector_gen #(.WIDTH(4), .GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .vec_ready(ready0),
    .a(a0), .b(b0), .cin(cin0), .vec_valid(valid0), .vec_last(last0),
    .busy(busy0), .done(done0), .vec_count(count0)
  );

  adder_vector_gen #(.WIDTH(4), .GAP(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .vec_ready(ready3),
    .a(a3), .b(b3), .cin(cin3), .vec_valid(valid3), .vec_last(last3),
    .busy(busy3), .done(done3), .vec_count(count3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {cin,b,a,valid,last,busy,done,count} packed for one-shot comparison
  function automatic logic [31:0] pk0();
    return {9'd0, cin0, b0, a0, valid0, last0, busy0, done0, count0};
  endfunction

  function automatic logic [31:0] pk3();
    return {9'd0, cin3, b3, a3, valid3, last3, busy3, done3, count3};
  endfunction

  function automatic logic [31:0] ex(input int idx, input bit v, input bit l,
                                     input bit bz, input bit d, input int cnt);
    logic [8:0] i9;
    logic [9:0] c10;
    i9  = idx[8:0];
    c10 = cnt[9:0];
    return {9'd0, i9, v, l, bz, d, c10};
  endfunction

  int  exp_idx;
  int  hold;
  int  k;
  int  done_at;
  bit  fin;
  bit  r;

  initial begin
    rst_n = 1'b0;
    start0 = 1'b0; abort0 = 1'b0; ready0 = 1'b0;
    start3 = 1'b0; abort3 = 1'b0; ready3 = 1'b0;
    repeat (3) step();
    chk("reset0", pk0(), ex(0, 0, 0, 0, 0, 0));
    chk("reset3", pk3(), ex(0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle0", pk0(), ex(0, 0, 0, 0, 0, 0));
    end
    chk("idle3", pk3(), ex(0, 0, 0, 0, 0, 0));

    // Full GAP=0 sweep with backpressure at idx 37 and a stray start at idx 200
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    exp_idx = 0; hold = 0; fin = 1'b0;
    for (int i = 0; i < 700 && !fin; i++) begin
      chk("sweep", pk0(), ex(exp_idx, 1, exp_idx == 511, 1, 0, exp_idx));
      r = !(exp_idx == 37 && hold < 7);
      if (!r) hold++;
      ready0 = r;
      start0 = (exp_idx == 200);
      step();
      start0 = 1'b0;
      if (r) begin
        if (exp_idx == 511) fin = 1'b1;
        else exp_idx++;
      end
    end
    chk("hold_cycles", hold, 7);
    chk("sweep_done", pk0(), ex(511, 0, 0, 0, 1, 512));
    step();
    chk("done_held", pk0(), ex(511, 0, 0, 0, 1, 512));

    // Restart from DONE, then abort coinciding with an accept at idx 100
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("restart", pk0(), ex(0, 1, 0, 1, 0, 0));
    exp_idx = 0;
    for (int i = 0; i < 200 && exp_idx < 100; i++) begin
      ready0 = 1'b1;
      step();
      exp_idx++;
    end
    chk("pre_abort", pk0(), ex(100, 1, 0, 1, 0, 100));
    abort0 = 1'b1; ready0 = 1'b1;
    step();
    abort0 = 1'b0;
    chk("abort", pk0(), ex(0, 0, 0, 0, 0, 100));
    repeat (3) step();
    chk("abort_idle", pk0(), ex(0, 0, 0, 0, 0, 100));
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("after_abort", pk0(), ex(0, 1, 0, 1, 0, 0));
    step();
    chk("after_abort2", pk0(), ex(1, 1, 0, 1, 0, 1));
    abort0 = 1'b1;
    step();
    abort0 = 1'b0; ready0 = 1'b0;

    // GAP=3 sweep: one valid cycle then three idle, 2045 cycles to done
    ready3 = 1'b1;
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    done_at = -1;
    k = 0;
    for (int i = 0; i < 2200 && done_at < 0; i++) begin
      if (done3) begin
        done_at = k;
      end else begin
        chk("gap_valid", valid3, (k % 4) == 0);
        if ((k % 4) == 0) chk("gap_idx", {cin3, b3, a3}, k / 4);
        step();
        k++;
      end
    end
    chk("gap_len", done_at, 512 * 4 - 3);
    chk("gap_done", pk3(), ex(511, 0, 0, 0, 1, 512));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
